// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Pipeline stage register with an optional skid entry, used between pipeline
// stages (IF/ID, EX/MEM, ...) to break the ready path and absorb one cycle of
// downstream backpressure without losing throughput.
//
// SKID = 1 : two-entry buffer (main + skid). in_ready is a pure register
//            output and does not depend on out_ready in the same cycle.
// SKID = 0 : single main register. in_ready = ~out_valid | out_ready
//            (combinational pass-through of downstream ready).
//
// Ports
//   clk          sole clock, all state updates on the rising edge
//   rst          asynchronous active-low reset (0 = reset)
//   flush        synchronous discard of every held entry (redirect)
//   in_valid     upstream presents a valid payload
//   in_ready     block accepts the payload this cycle
//   in_data      upstream payload, WIDTH bits
//   out_valid    out_data holds a valid payload
//   out_ready    downstream consumes the head payload this cycle
//   out_data     head payload, WIDTH bits (all zero when empty)
//   occupancy    number of entries held (0..2, at most 1 when SKID = 0)
//   stall_count  saturating count of cycles with out_valid & ~out_ready
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
   parameter int WIDTH = 32,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_count
);

   // State encoding equals the number of held entries.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t             state_r;
   logic [WIDTH-1:0]   main_r;
   logic [WIDTH-1:0]   skid_r;
   logic               valid_r;
   // SKID=1: the registered in_ready itself.
   // SKID=0: "out of reset" qualifier so in_ready stays low until the
   //         first clock edge after reset release.
   logic               rdy_r;
   logic [CNT_W-1:0]   stall_r;

   logic               in_ready_s;
   logic               accept_s;
   logic               emit_s;
   logic               stall_s;

   // Upstream ready: registered for the skid variant, pass-through otherwise.
   always_comb begin
      in_ready_s = 1'b0;
      if (SKID != 0) begin
         in_ready_s = rdy_r;
      end else begin
         in_ready_s = rdy_r & (~valid_r | out_ready);
      end
   end

   assign accept_s = in_valid & in_ready_s;
   assign emit_s   = valid_r & out_ready;
   assign stall_s  = valid_r & ~out_ready;

   // Occupancy FSM together with the payload registers and registered flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_EMPTY;
         main_r  <= {WIDTH{1'b0}};
         skid_r  <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
         rdy_r   <= 1'b0;
      end else if (flush) begin
         // Flush wins over accept/emit; the payload offered this cycle is
         // dropped, a concurrent emit has already been taken downstream.
         state_r <= ST_EMPTY;
         main_r  <= {WIDTH{1'b0}};
         skid_r  <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
         rdy_r   <= 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               rdy_r <= 1'b1;
               if (accept_s) begin
                  state_r <= ST_ONE;
                  main_r  <= in_data;
                  valid_r <= 1'b1;
               end else begin
                  state_r <= ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && emit_s) begin
                  main_r <= in_data;
                  rdy_r  <= 1'b1;
               end else if (accept_s) begin
                  if (SKID != 0) begin
                     // Downstream stalled: park the new payload behind main.
                     state_r <= ST_FULL;
                     skid_r  <= in_data;
                     rdy_r   <= 1'b0;
                  end else begin
                     // Unreachable without skid (accept implies emit).
                     main_r <= in_data;
                     rdy_r  <= 1'b1;
                  end
               end else if (emit_s) begin
                  state_r <= ST_EMPTY;
                  main_r  <= {WIDTH{1'b0}};
                  valid_r <= 1'b0;
                  rdy_r   <= 1'b1;
               end else begin
                  rdy_r <= 1'b1;
               end
            end
            ST_FULL: begin
               if (emit_s) begin
                  // Skid entry moves up to the head; a slot frees up.
                  state_r <= ST_ONE;
                  main_r  <= skid_r;
                  skid_r  <= {WIDTH{1'b0}};
                  rdy_r   <= 1'b1;
               end else begin
                  rdy_r <= 1'b0;
               end
            end
            default: begin
               // Illegal encoding: recover to a clean empty stage.
               state_r <= ST_EMPTY;
               main_r  <= {WIDTH{1'b0}};
               skid_r  <= {WIDTH{1'b0}};
               valid_r <= 1'b0;
               rdy_r   <= 1'b1;
            end
         endcase
      end
   end

   // Saturating stall counter; flush does not touch it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_r <= {CNT_W{1'b0}};
      end else if (stall_s && (stall_r != {CNT_W{1'b1}})) begin
         stall_r <= stall_r + CNT_W'(1'b1);
      end else begin
         stall_r <= stall_r;
      end
   end

   assign in_ready    = in_ready_s;
   assign out_valid   = valid_r;
   assign out_data    = main_r;
   assign occupancy   = state_r;
   assign stall_count = stall_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   // Skid instance, default widths
   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_data, a_out_data;
   logic [1:0]  a_occ;
   logic [15:0] a_stall;

   // Skid instance with a 2-bit stall counter
   logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [7:0]  c_in_data, c_out_data;
   logic [1:0]  c_occ;
   logic [1:0]  c_stall;

   // Single-register instance
   logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
   logic [31:0] z_in_data, z_out_data;
   logic [1:0]  z_occ;
   logic [15:0] z_stall;

   pipe_skid_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .occupancy(a_occ), .stall_count(a_stall)
   );

   pipe_skid_reg #(.WIDTH(8), .SKID(1), .CNT_W(2)) u_cnt (
      .clk(clk), .rst(rst), .flush(c_flush),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .occupancy(c_occ), .stall_count(c_stall)
   );

   pipe_skid_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_s0 (
      .clk(clk), .rst(rst), .flush(z_flush),
      .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
      .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
      .occupancy(z_occ), .stall_count(z_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL rst_occ: got %0d want 0", a_occ); end
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", a_out_valid); end
      total++; if (a_out_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", a_out_data); end
      total++; if (a_stall !== 16'd0) begin bad++; $display("FAIL rst_stall: got %0d want 0", a_stall); end
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
      total++; if (z_in_ready !== 1'b0) begin bad++; $display("FAIL rst_s0_in_ready: got %b want 0", z_in_ready); end
      rst = 1'b1;
      #1;
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rel_before_edge: got %b want 0", a_in_ready); end
      step();
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b want 1", a_in_ready); end
      total++; if (z_in_ready !== 1'b1) begin bad++; $display("FAIL rel_s0_in_ready: got %b want 1", z_in_ready); end
   endtask

   task automatic test_stream;
      logic [31:0] vec [3];
      vec[0] = 32'h1; vec[1] = 32'h2; vec[2] = 32'h3;
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_in_data = vec[i];
         step();
         total++; if (a_out_data !== vec[i]) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, a_out_data, vec[i]); end
         total++; if (a_occ !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, a_occ); end
         total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_in_ready); end
      end
      a_in_valid = 1'b0;
      step();
      total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL stream_drain_occ: got %0d want 0", a_occ); end
      total++; if (a_out_data !== 32'h0) begin bad++; $display("FAIL stream_drain_data: got %h want 0", a_out_data); end
   endtask

   task automatic test_backpressure;
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 32'hA;
      step();
      total++; if (a_occ !== 2'd1) begin bad++; $display("FAIL bp_occ1: got %0d want 1", a_occ); end
      a_in_data = 32'hB;
      step();
      total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL bp_occ2: got %0d want 2", a_occ); end
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", a_in_ready); end
      total++; if (a_out_data !== 32'hA) begin bad++; $display("FAIL bp_head: got %h want a", a_out_data); end
      // Offered while full: must not be taken
      a_in_data = 32'hD;
      step();
      total++; if (a_out_data !== 32'hA) begin bad++; $display("FAIL bp_hold: got %h want a", a_out_data); end
      total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL bp_hold_occ: got %0d want 2", a_occ); end
      total++; if (a_stall !== 16'd2) begin bad++; $display("FAIL bp_stall: got %0d want 2", a_stall); end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      step();
      total++; if (a_out_data !== 32'hB) begin bad++; $display("FAIL bp_second: got %h want b", a_out_data); end
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back: got %b want 1", a_in_ready); end
      total++; if (a_occ !== 2'd1) begin bad++; $display("FAIL bp_occ_after: got %0d want 1", a_occ); end
      step();
      total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL bp_empty: got %0d want 0", a_occ); end
   endtask

   task automatic test_flush;
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 32'hA;
      step();
      a_in_data = 32'hB;
      step();
      total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL fl_pre_occ: got %0d want 2", a_occ); end
      a_flush   = 1'b1;
      a_in_data = 32'hC;
      step();
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL fl_occ: got %0d want 0", a_occ); end
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b want 0", a_out_valid); end
      total++; if (a_out_data !== 32'h0) begin bad++; $display("FAIL fl_data: got %h want 0", a_out_data); end
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL fl_in_ready: got %b want 1", a_in_ready); end
      total++; if (a_stall !== 16'd4) begin bad++; $display("FAIL fl_stall: got %0d want 4", a_stall); end
      a_out_ready = 1'b1;
      step();
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL fl_no_c: got %b want 0", a_out_valid); end
      total++; if (a_out_data !== 32'h0) begin bad++; $display("FAIL fl_no_c_data: got %h want 0", a_out_data); end
   endtask

   task automatic test_stall_sat;
      logic [1:0] exp_cnt [5];
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
      exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
      c_out_ready = 1'b0;
      c_in_valid  = 1'b1;
      c_in_data   = 8'h11;
      step();
      c_in_valid = 1'b0;
      total++; if (c_stall !== 2'd0) begin bad++; $display("FAIL sat_start: got %0d want 0", c_stall); end
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (c_stall !== exp_cnt[i]) begin bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, c_stall, exp_cnt[i]); end
      end
      total++; if (c_out_data !== 8'h11) begin bad++; $display("FAIL sat_hold: got %h want 11", c_out_data); end
   endtask

   task automatic test_skid0;
      z_out_ready = 1'b0;
      z_in_valid  = 1'b1;
      z_in_data   = 32'h55;
      #1;
      total++; if (z_in_ready !== 1'b1) begin bad++; $display("FAIL s0_empty_ready: got %b want 1", z_in_ready); end
      step();
      total++; if (z_occ !== 2'd1) begin bad++; $display("FAIL s0_occ: got %0d want 1", z_occ); end
      total++; if (z_out_data !== 32'h55) begin bad++; $display("FAIL s0_data: got %h want 55", z_out_data); end
      z_in_data = 32'h66;
      #1;
      total++; if (z_in_ready !== 1'b0) begin bad++; $display("FAIL s0_blocked: got %b want 0", z_in_ready); end
      step();
      total++; if (z_out_data !== 32'h55) begin bad++; $display("FAIL s0_hold: got %h want 55", z_out_data); end
      z_out_ready = 1'b1;
      #1;
      total++; if (z_in_ready !== 1'b1) begin bad++; $display("FAIL s0_pass_ready: got %b want 1", z_in_ready); end
      step();
      total++; if (z_out_data !== 32'h66) begin bad++; $display("FAIL s0_replace: got %h want 66", z_out_data); end
      total++; if (z_occ !== 2'd1) begin bad++; $display("FAIL s0_occ_replace: got %0d want 1", z_occ); end
      z_in_valid = 1'b0;
      step();
      total++; if (z_occ !== 2'd0) begin bad++; $display("FAIL s0_drain: got %0d want 0", z_occ); end
      total++; if (z_out_data !== 32'h0) begin bad++; $display("FAIL s0_drain_data: got %h want 0", z_out_data); end
   endtask

   task automatic test_async_reset;
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 32'h11;
      step();
      a_in_data = 32'h22;
      step();
      total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL ar_pre_occ: got %0d want 2", a_occ); end
      #3;
      rst = 1'b0;
      #1;
      total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL ar_occ: got %0d want 0", a_occ); end
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", a_out_valid); end
      total++; if (a_out_data !== 32'h0) begin bad++; $display("FAIL ar_data: got %h want 0", a_out_data); end
      total++; if (a_stall !== 16'd0) begin bad++; $display("FAIL ar_stall: got %0d want 0", a_stall); end
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL ar_in_ready: got %b want 0", a_in_ready); end
      // in_valid stays high across an edge in reset: nothing may be taken
      step();
      total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL ar_no_accept: got %0d want 0", a_occ); end
      a_in_valid = 1'b0;
      rst = 1'b1;
      step();
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL ar_release: got %b want 1", a_in_ready); end
      total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL ar_release_occ: got %0d want 0", a_occ); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 32'h0; a_out_ready = 1'b0;
      c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = 8'h0;  c_out_ready = 1'b0;
      z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = 32'h0; z_out_ready = 1'b0;
      step();
      step();
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_stall_sat();
      test_skid0();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: WIDTH, 32, payload width in bits (stage-struct width, e.g. IF/ID or EX/MEM bundle).
REQ-002 Parameter: SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-003 Parameter: CNT_W, 16, width of stall counter.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-007 flush  input  1  synchronous discard of all held entries (branch/jump redirect).
REQ-008 in_valid  input  1  upstream stage holds a valid payload.
REQ-009 in_ready  output  1  block accepts payload this cycle.
REQ-010 in_data  input  WIDTH  upstream payload.
REQ-011 out_valid  output  1  out_data is a valid payload.
REQ-012 out_ready  input  1  downstream consumes payload this cycle (e.g. memory resp gating).
REQ-013 out_data  output  WIDTH  head payload.
REQ-014 occupancy  output  2  entries held (0..2; max 1 when SKID=0).
REQ-015 stall_count  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Accept = in_valid & in_ready; emit = out_valid & out_ready; both evaluated on same edge.
REQ-017 Storage: main register (drives out_data) and, when SKID=1, one skid register; out_valid = occupancy != 0.
REQ-018 Latency in_data -> out_data: 1 cycle from accept into empty block; sustained throughput 1 payload/cycle with out_ready held 1.
REQ-019 SKID=1 states EMPTY(0), ONE(1), FULL(2); in_ready = (state != FULL), a pure register output independent of out_ready.
REQ-020 EMPTY: accept -> ONE, main <= in_data; else stay.
REQ-021 ONE: accept&emit -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; emit only -> EMPTY; neither -> stay.
REQ-022 FULL: emit -> ONE, main <= skid; no accept possible; else stay, both registers held.
REQ-023 SKID=0: in_ready = ~out_valid | out_ready (combinational); accept loads main; emit without accept -> empty.
REQ-024 Payload order strictly FIFO; no payload duplicated or dropped except by flush.
REQ-025 flush (highest priority over accept/emit): next state EMPTY, main and skid cleared to 0; payload presented that cycle discarded even if in_ready=1; emit that cycle still counts as consumed downstream.
REQ-026 While held (no emit), out_data stable; out_data = 0 whenever occupancy = 0.
REQ-027 stall_count increments by 1 per stall cycle, saturates at 2^CNT_W-1, unaffected by flush.

Reset
REQ-028 While rst=0, asynchronously: state EMPTY, occupancy 0, out_valid 0, out_data 0, stall_count 0, in_ready 0.
REQ-029 First rising edge after rst deasserts: in_ready 1; no accept occurs while rst=0.
REQ-030 Reset mid-operation discards all held entries; no partial update survives.

Verification
REQ-031 Streaming: SKID=1, out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later, occupancy stays 1, in_ready stays 1.
REQ-032 Backpressure: SKID=1, load 0xA then 0xB with out_ready=0 -> occupancy 2, in_ready 0, out_data 0xA held; raise out_ready -> 0xA then 0xB emitted, in_ready returns 1 after first emit.
REQ-033 Flush: FULL with 0xA/0xB, flush=1 with in_valid=1, in_data=0xC -> next cycle occupancy 0, out_valid 0, out_data 0; 0xC never emitted.
REQ-034 Stall counter: CNT_W=2, hold out_valid=1 with out_ready=0 for 5 cycles -> stall_count 1,2,3,3,3.
REQ-035 SKID=0: occupancy 1, out_ready=1, in_valid=1 -> in_ready=1 same cycle, main replaced; out_ready=0 -> in_ready=0.
REQ-036 Async reset: drive rst=0 between edges while occupancy 2 -> outputs zero immediately without clock edge; after release in_ready=1 on next edge.
